// File: rtl/frame_pixel_source.sv
// Raster-order frame reader that turns a synchronous-read image memory into a pixel stream.
// Fixed 2-cycle issue-to-output latency; hold stalls read issue, and reads already in flight still drain.
module frame_pixel_source #(
    parameter int IMG_WIDTH  = 256,
    parameter int IMG_HEIGHT = 256,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        pixel_out,
    output logic              valid_out,
    output logic              sof_out,
    output logic              eol_out,
    output logic              eof_out,
    output logic              busy,
    output logic              done
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_WIDTH * IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [2:0]        tag_now;
    logic [2:0]        tag_q;
    logic [2:0]        tag_d1;
    logic              rd_d1;

    // Marker order within the tag vectors is {sof, eol, eof}.
    always_comb begin
        tag_now    = 3'b000;
        tag_now[2] = (col == '0) && (row == '0);
        tag_now[1] = (col == LAST_COL);
        tag_now[0] = (col == LAST_COL) && (row == LAST_ROW);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            col       <= '0;
            row       <= '0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            tag_q     <= 3'b000;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    mem_rd_en <= 1'b0;
                    if (start) begin
                        state <= READ;
                        cnt   <= '0;
                        col   <= '0;
                        row   <= '0;
                        busy  <= 1'b1;
                    end
                end
                READ: begin
                    if (hold) begin
                        mem_rd_en <= 1'b0;
                    end else begin
                        mem_addr  <= cnt;
                        mem_rd_en <= 1'b1;
                        tag_q     <= tag_now;
                        cnt       <= cnt + 1'b1;
                        if (col == LAST_COL) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (cnt == LAST_ADDR) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    mem_rd_en <= 1'b0;
                    // eof_out is registered, so the frame is complete one edge after the eof beat.
                    if (eof_out) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_rd_en <= 1'b0;
                end
            endcase
        end
    end

    // The first stage tracks the memory access; the second lines up with mem_rdata.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_d1     <= 1'b0;
            tag_d1    <= 3'b000;
            valid_out <= 1'b0;
            sof_out   <= 1'b0;
            eol_out   <= 1'b0;
            eof_out   <= 1'b0;
            pixel_out <= 8'd0;
        end else begin
            rd_d1     <= mem_rd_en;
            tag_d1    <= mem_rd_en ? tag_q : 3'b000;
            valid_out <= rd_d1;
            sof_out   <= rd_d1 & tag_d1[2];
            eol_out   <= rd_d1 & tag_d1[1];
            eof_out   <= rd_d1 & tag_d1[0];
            if (rd_d1) begin
                pixel_out <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_frame_pixel_source.sv
// Directed bench for frame_pixel_source: 4x2, 2x1 and 16x16 instances that share clock and reset.
module tb_frame_pixel_source;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start;
    logic hold;
    int   sel;
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;

    logic [15:0] a_addr, b_addr, c_addr;
    logic        a_rd, b_rd, c_rd;
    logic [7:0]  a_rdata, b_rdata, c_rdata;
    logic [7:0]  a_pix, b_pix, c_pix;
    logic        a_vld, b_vld, c_vld;
    logic        a_sof, b_sof, c_sof;
    logic        a_eol, b_eol, c_eol;
    logic        a_eof, b_eof, c_eof;
    logic        a_busy, b_busy, c_busy;
    logic        a_done, b_done, c_done;

    frame_pixel_source #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .ADDR_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(start && sel == 0), .hold(hold && sel == 0),
        .mem_addr(a_addr), .mem_rd_en(a_rd), .mem_rdata(a_rdata),
        .pixel_out(a_pix), .valid_out(a_vld), .sof_out(a_sof), .eol_out(a_eol),
        .eof_out(a_eof), .busy(a_busy), .done(a_done));

    frame_pixel_source #(.IMG_WIDTH(2), .IMG_HEIGHT(1), .ADDR_W(16)) dut_b (
        .clk(clk), .rst(rst), .start(start && sel == 1), .hold(hold && sel == 1),
        .mem_addr(b_addr), .mem_rd_en(b_rd), .mem_rdata(b_rdata),
        .pixel_out(b_pix), .valid_out(b_vld), .sof_out(b_sof), .eol_out(b_eol),
        .eof_out(b_eof), .busy(b_busy), .done(b_done));

    frame_pixel_source #(.IMG_WIDTH(16), .IMG_HEIGHT(16), .ADDR_W(16)) dut_c (
        .clk(clk), .rst(rst), .start(start && sel == 2), .hold(hold && sel == 2),
        .mem_addr(c_addr), .mem_rd_en(c_rd), .mem_rdata(c_rdata),
        .pixel_out(c_pix), .valid_out(c_vld), .sof_out(c_sof), .eol_out(c_eol),
        .eof_out(c_eof), .busy(c_busy), .done(c_done));

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    function automatic logic [7:0] exp_pix(input int s, input int i);
        return (s == 2) ? pat(i) : 8'((i + 1) & 255);
    endfunction

    // Synchronous-read image memories
    always @(posedge clk) begin
        if (a_rd) a_rdata <= 8'((int'(a_addr) + 1) & 255);
        if (b_rd) b_rdata <= 8'((int'(b_addr) + 1) & 255);
        if (c_rd) c_rdata <= pat(int'(c_addr));
    end

    logic [15:0] o_addr;
    logic [7:0]  o_pix;
    logic        o_rd, o_vld, o_sof, o_eol, o_eof, o_busy, o_done;

    always_comb begin
        {o_addr, o_rd, o_pix, o_vld, o_sof, o_eol, o_eof, o_busy, o_done} = '0;
        case (sel)
            0: {o_addr, o_rd, o_pix, o_vld, o_sof, o_eol, o_eof, o_busy, o_done} =
               {a_addr, a_rd, a_pix, a_vld, a_sof, a_eol, a_eof, a_busy, a_done};
            1: {o_addr, o_rd, o_pix, o_vld, o_sof, o_eol, o_eof, o_busy, o_done} =
               {b_addr, b_rd, b_pix, b_vld, b_sof, b_eol, b_eof, b_busy, b_done};
            2: {o_addr, o_rd, o_pix, o_vld, o_sof, o_eol, o_eof, o_busy, o_done} =
               {c_addr, c_rd, c_pix, c_vld, c_sof, c_eol, c_eof, c_busy, c_done};
            default: ;
        endcase
    end

    // Monitor samples 1 time unit after each rising edge; cyc numbers the edges.
    logic [10:0] bq[$];
    int          cq[$];
    int          n_done = 0;
    int          done_c = 0;
    int          busy_n = 0;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (o_vld) begin
            bq.push_back({o_pix, o_sof, o_eol, o_eof});
            cq.push_back(cyc);
        end
        if (o_done) begin
            n_done++;
            done_c = cyc;
        end
        if (o_busy) busy_n++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear();
        bq.delete();
        cq.delete();
        n_done = 0;
        busy_n = 0;
    endtask

    task automatic launch(output int sc);
        @(negedge clk);
        start = 1'b1;
        sc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd_hold);
        int k = 0;
        while (n_done == 0 && k < budget) begin
            @(negedge clk);
            if (rnd_hold) hold = ($urandom_range(0, 3) == 0);
            k++;
        end
        hold = 1'b0;
        if (n_done == 0) chk("done_timeout", 0, 1);
    endtask

    task automatic check_frame(input string nm, input int w, input int h, input int sc, input bit timed);
        logic [10:0] b;
        chk({nm, "_beats"}, bq.size(), w * h);
        for (int i = 0; i < bq.size() && i < w * h; i++) begin
            b = bq[i];
            chk($sformatf("%s_pix%0d", nm, i), b[10:3], exp_pix(sel, i));
            chk($sformatf("%s_sof%0d", nm, i), b[2], i == 0);
            chk($sformatf("%s_eol%0d", nm, i), b[1], (i % w) == w - 1);
            chk($sformatf("%s_eof%0d", nm, i), b[0], i == w * h - 1);
            if (timed) chk($sformatf("%s_cyc%0d", nm, i), cq[i], sc + 3 + i);
        end
        chk({nm, "_ndone"}, n_done, 1);
        if (timed) begin
            chk({nm, "_done_cyc"}, done_c, sc + 3 + w * h);
            chk({nm, "_busy_cycles"}, busy_n, w * h + 3);
        end
    endtask

    initial begin
        int sc;
        int sc2;
        int k;
        rst = 1'b0;
        start = 1'b0;
        hold = 1'b0;
        sel = 0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk($sformatf("rst%0d_outs", s), {o_vld, o_sof, o_eol, o_eof, o_busy, o_done, o_rd}, 0);
            chk($sformatf("rst%0d_pix", s), o_pix, 0);
            chk($sformatf("rst%0d_addr", s), o_addr, 0);
        end
        @(negedge clk);
        rst = 1'b1;

        // 4x2 unheld frame
        sel = 0;
        clear();
        launch(sc);
        wait_done(60, 1'b0);
        repeat (4) @(negedge clk);
        check_frame("plain", 4, 2, sc, 1'b1);

        // Two-cycle hold after the third issue
        clear();
        launch(sc);
        repeat (3) @(negedge clk);
        hold = 1'b1;
        repeat (2) @(negedge clk);
        hold = 1'b0;
        wait_done(60, 1'b0);
        repeat (4) @(negedge clk);
        check_frame("hold", 4, 2, sc, 1'b0);
        if (cq.size() >= 4) begin
            chk("hold_p3_cyc", cq[2], sc + 5);
            chk("hold_p4_cyc", cq[3], sc + 8);
        end
        chk("hold_done_cyc", done_c, sc + 13);

        // Start mid-frame and in DRAIN is ignored; start in the done cycle relaunches
        clear();
        launch(sc);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(60, 1'b0);
        check_frame("ign", 4, 2, sc, 1'b1);
        start = 1'b1;
        sc2 = cyc + 1;
        clear();
        @(negedge clk);
        start = 1'b0;
        wait_done(60, 1'b0);
        repeat (4) @(negedge clk);
        check_frame("relaunch", 4, 2, sc2, 1'b1);

        // Reset pulse after pixel 5
        clear();
        launch(sc);
        k = 0;
        while (bq.size() < 5 && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("abort_p5_seen", bq.size(), 5);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort_outs", {o_vld, o_sof, o_eol, o_eof, o_busy, o_done, o_rd}, 0);
        chk("abort_pix", o_pix, 0);
        chk("abort_addr", o_addr, 0);
        repeat (10) @(negedge clk);
        chk("abort_no_more_beats", bq.size(), 5);
        chk("abort_no_done", n_done, 0);
        chk("abort_idle", o_busy, 0);
        clear();
        launch(sc);
        wait_done(60, 1'b0);
        repeat (4) @(negedge clk);
        check_frame("after_rst", 4, 2, sc, 1'b1);

        // Minimum 2x1 frame
        sel = 1;
        clear();
        launch(sc);
        wait_done(40, 1'b0);
        repeat (4) @(negedge clk);
        check_frame("w2h1", 2, 1, sc, 1'b1);

        // 16x16 frame under random hold
        sel = 2;
        clear();
        launch(sc);
        wait_done(3000, 1'b1);
        repeat (4) @(negedge clk);
        check_frame("rnd16", 16, 16, sc, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_pixel_source.md
# frame_pixel_source

Pixel-stream source that reads one greyscale frame out of a synchronous-read image memory in raster order and drives it onto the `pixel`/`valid` stream consumed by the point-processing blocks, such as brightness adjustment. A `start` pulse launches one frame. The `hold` input throttles read issue. Frame and line markers travel alongside each pixel, and `done` pulses when the last pixel has left the block.

## Interface
- `IMG_WIDTH`, default 256: pixels per line; must be ≥ 2.
- `IMG_HEIGHT`, default 256: lines per frame; must be ≥ 1.
- `ADDR_W`, default 16: memory address width; IMG_WIDTH*IMG_HEIGHT ≤ 2^ADDR_W.
- `clk`  in  1  single clock domain; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset (0 = reset).
- `start`  in  1  launches one frame when sampled high in IDLE; ignored otherwise.
- `hold`  in  1  when high, no new read is issued this cycle; reads already in flight still complete.
- `mem_addr`  out  ADDR_W  registered read address, linear: row*IMG_WIDTH+col.
- `mem_rd_en`  out  1  registered read strobe.
- `mem_rdata`  in  8  memory read data, valid one cycle after the edge that samples `mem_addr`/`mem_rd_en`.
- `pixel_out`  out  8  output pixel.
- `valid_out`  out  1  `pixel_out` is valid this cycle.
- `sof_out`  out  1  qualifies pixel (0,0); high only when `valid_out` is high.
- `eol_out`  out  1  qualifies the last pixel of each line.
- `eof_out`  out  1  qualifies the last pixel of the frame.
- `busy`  out  1  a frame is in progress.
- `done`  out  1  one-cycle pulse when the frame is complete.

## Operation
- FSM states: IDLE, READ, DRAIN.
- IDLE: `start`=1 → READ. Clear the linear, column and row counters; `busy`<=1; no read is issued on this edge.
- READ, each edge:
  - `hold`=0: `mem_addr`<=cnt, `mem_rd_en`<=1, and tags sof/eol/eof are computed from col/row and pushed into the side pipeline.
  - Then cnt++. col wraps IMG_WIDTH-1→0 with row++.
  - `hold`=1: `mem_rd_en`<=0; counters are unchanged.
  - Issuing address IMG_WIDTH*IMG_HEIGHT-1 → DRAIN.
- DRAIN: `mem_rd_en`<=0. Stay until the eof beat has been output, then → IDLE with `done`<=1 and `busy`<=0.
- Output stage:
  - `valid_out` and the tags are the read strobe/tags delayed two stages, aligned with `mem_rdata`.
  - `pixel_out`<=`mem_rdata` when the delayed strobe is 1.
  - `pixel_out` holds its last value while `valid_out`=0.
- `start` in READ/DRAIN is ignored. `start` in the `done` cycle (IDLE) is accepted.
- `hold` has no effect in IDLE or DRAIN.
- Reset is applied at any time, including mid-frame:
  - Everything goes to reset values on the next edge and the frame is aborted.
  - No `done` pulse for the aborted frame.
  - In-flight read data is discarded.
- Reset values: `mem_addr`=0, `mem_rd_en`=0, `pixel_out`=0, `valid_out`=0, `sof_out`/`eol_out`/`eof_out`=0, `busy`=0, `done`=0; state IDLE.
- Address arithmetic is unsigned ADDR_W and never wraps within a frame.

## Timing
- Edge E0 samples `start`. The first read issues at E1 if `hold`=0. With `hold`=0 throughout, `mem_rd_en`=1 for exactly W*H consecutive cycles starting after E1.
- Read issued at edge Ek:
  - `mem_rdata` is valid after Ek+1.
  - `valid_out`/`pixel_out` are valid after Ek+2.
  - Fixed latency: 2 cycles from issue to output.
- First `valid_out` is 3 cycles after the start edge when unheld.
- `hold` raised for N cycles produces exactly N bubbles in `mem_rd_en` and, 2 cycles later, N bubbles in `valid_out`. Pixel order is unaffected.
- `done` is high the cycle immediately after the eof beat. `busy` falls on that same edge.
- Unheld frame: `busy` is high for W*H+3 cycles.

## Test plan
- W=4, H=2, mem[i]=i+1, `hold`=0, one `start` pulse:
  - `pixel_out` sequence is 1..8 on 8 consecutive cycles, the first 3 cycles after start.
  - `sof_out` on pixel 1, `eol_out` on pixels 4 and 8, `eof_out` on 8.
  - `done` pulses the next cycle.
- Same frame, `hold`=1 for 2 cycles after the third issue: `valid_out` shows a 2-cycle gap between pixels 3 and 4; the sequence is still 1..8, and `done` arrives 2 cycles later than unheld.
- `start` pulsed again mid-frame and during DRAIN: ignored, exactly 8 pixels and one `done`. `start` in the `done` cycle launches a second full frame immediately.
- `rst`=0 for one cycle after pixel 5 is output:
  - All outputs are 0 next cycle and no further `valid_out`.
  - No `done` pulse; state is IDLE.
  - A subsequent `start` yields a clean 1..8 frame.
- W=2, H=1: pixels 1,2, with `sof_out`+… on pixel 1 and `eol_out`+`eof_out` on pixel 2; `done` after pixel 2; `busy` high 5 cycles.
- Random `hold` over a 16×16 frame: output equals mem in raster order, exactly 256 beats, markers correct on every line.
